// File: rtl/noc_credit_link_buf.sv
// noc_credit_link_buf: credit-flow-controlled link buffer between two mesh router ports.
// One FIFO per VC, round-robin egress under per-VC downstream credits, one upstream credit per dequeue.
// Ports: clk, reset (sync, active-high); up_flit_valid/vc/data in; up_credit_valid/vc out;
//   dn_flit_valid/vc/data out (registered); dn_credit_valid/vc in; error (sticky) out;
//   flit_count/stall_count out (live only when NOC_LINK_STATS_EN is defined, else tied to 0).
module noc_credit_link_buf #(
  parameter int FLIT_WIDTH = 64,
  parameter int NUM_VCS    = 4,
  parameter int BUF_DEPTH  = 4,
  parameter int DN_CREDITS = 4,
  parameter int VC_W       = (NUM_VCS > 1) ? $clog2(NUM_VCS) : 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  up_flit_valid,
  input  logic [VC_W-1:0]       up_flit_vc,
  input  logic [FLIT_WIDTH-1:0] up_flit_data,
  output logic                  up_credit_valid,
  output logic [VC_W-1:0]       up_credit_vc,
  output logic                  dn_flit_valid,
  output logic [VC_W-1:0]       dn_flit_vc,
  output logic [FLIT_WIDTH-1:0] dn_flit_data,
  input  logic                  dn_credit_valid,
  input  logic [VC_W-1:0]       dn_credit_vc,
  output logic                  error,
  output logic [31:0]           flit_count,
  output logic [31:0]           stall_count
);
  localparam int PW = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
  localparam int CW = $clog2(BUF_DEPTH + 1);
  localparam int KW = $clog2(DN_CREDITS + 1);
  logic [FLIT_WIDTH-1:0] r_mem [NUM_VCS][BUF_DEPTH];
  logic [PW-1:0]         r_rd [NUM_VCS];
  logic [PW-1:0]         r_wr [NUM_VCS];
  logic [CW-1:0]         r_cnt [NUM_VCS];
  logic [KW-1:0]         r_cred [NUM_VCS];
  logic [VC_W-1:0]       r_rr, r_dn_vc;
  logic                  r_dn_valid, r_err;
  logic [FLIT_WIDTH-1:0] r_dn_data;
  logic [NUM_VCS-1:0]    w_busy, w_elig, w_wr, w_rd, w_cr;
  logic                  w_gnt, w_up_vc_ok, w_cr_vc_ok, w_up_ok, w_cr_sat, w_err;
  logic [VC_W-1:0]       w_gnt_vc, w_idx;
  always_comb begin
    w_busy = '0;
    w_elig = '0;
    for (int v = 0; v < NUM_VCS; v++) begin
      w_busy[v] = r_cnt[v] != '0;
      w_elig[v] = w_busy[v] && r_cred[v] != '0;
    end
  end
  // Search starts one past the last granted VC and wraps, so the last winner has lowest priority.
  always_comb begin
    w_gnt    = 1'b0;
    w_gnt_vc = '0;
    w_idx    = '0;
    for (int i = 1; i <= NUM_VCS; i++) begin
      w_idx = VC_W'((int'(r_rr) + i) % NUM_VCS);
      if (!w_gnt && w_elig[w_idx]) begin
        w_gnt    = 1'b1;
        w_gnt_vc = w_idx;
      end
    end
  end
  // A write into a full FIFO is legal when that FIFO is dequeued in the same cycle.
  assign w_up_vc_ok = 32'(up_flit_vc) < NUM_VCS;
  assign w_cr_vc_ok = 32'(dn_credit_vc) < NUM_VCS;
  assign w_up_ok    = up_flit_valid && w_up_vc_ok &&
                      (32'(r_cnt[up_flit_vc]) < BUF_DEPTH || (w_gnt && w_gnt_vc == up_flit_vc));
  assign w_cr_sat   = dn_credit_valid && w_cr_vc_ok && 32'(r_cred[dn_credit_vc]) == DN_CREDITS &&
                      !(w_gnt && w_gnt_vc == dn_credit_vc);
  assign w_err      = (up_flit_valid && !w_up_ok) || (dn_credit_valid && !w_cr_vc_ok) || w_cr_sat;
  always_comb begin
    w_wr = '0;
    w_rd = '0;
    w_cr = '0;
    for (int v = 0; v < NUM_VCS; v++) begin
      w_wr[v] = w_up_ok && up_flit_vc == VC_W'(v);
      w_rd[v] = w_gnt && w_gnt_vc == VC_W'(v);
      w_cr[v] = dn_credit_valid && dn_credit_vc == VC_W'(v);
    end
  end
  always_ff @(posedge clk)
    if (w_up_ok) r_mem[up_flit_vc][r_wr[up_flit_vc]] <= up_flit_data;
  always_ff @(posedge clk) begin
    if (reset) begin
      r_rr       <= VC_W'(NUM_VCS - 1);
      r_dn_valid <= 1'b0;
      r_dn_vc    <= '0;
      r_dn_data  <= '0;
      r_err      <= 1'b0;
      for (int v = 0; v < NUM_VCS; v++) begin
        r_rd[v]   <= '0;
        r_wr[v]   <= '0;
        r_cnt[v]  <= '0;
        r_cred[v] <= KW'(DN_CREDITS);
      end
    end else begin
      r_dn_valid <= w_gnt;
      r_dn_vc    <= w_gnt_vc;
      r_dn_data  <= w_gnt ? r_mem[w_gnt_vc][r_rd[w_gnt_vc]] : '0;
      r_err      <= r_err | w_err;
      if (w_gnt) r_rr <= w_gnt_vc;
      for (int v = 0; v < NUM_VCS; v++) begin
        if (w_wr[v]) r_wr[v] <= (32'(r_wr[v]) == BUF_DEPTH - 1) ? '0 : r_wr[v] + 1'b1;
        if (w_rd[v]) r_rd[v] <= (32'(r_rd[v]) == BUF_DEPTH - 1) ? '0 : r_rd[v] + 1'b1;
        if (w_wr[v] != w_rd[v]) r_cnt[v] <= w_wr[v] ? r_cnt[v] + 1'b1 : r_cnt[v] - 1'b1;
        // Grant and return on the same VC cancel; a return at the ceiling saturates.
        if (w_cr[v] && !w_rd[v] && 32'(r_cred[v]) != DN_CREDITS) r_cred[v] <= r_cred[v] + 1'b1;
        else if (w_rd[v] && !w_cr[v]) r_cred[v] <= r_cred[v] - 1'b1;
      end
    end
  end
  assign dn_flit_valid   = r_dn_valid;
  assign dn_flit_vc      = r_dn_vc;
  assign dn_flit_data    = r_dn_data;
  assign up_credit_valid = r_dn_valid;
  assign up_credit_vc    = r_dn_vc;
  assign error           = r_err;
`ifdef NOC_LINK_STATS_EN
  logic [31:0] r_flit_cnt, r_stall_cnt;
  always_ff @(posedge clk) begin
    if (reset) begin
      r_flit_cnt  <= '0;
      r_stall_cnt <= '0;
    end else begin
      r_flit_cnt  <= r_flit_cnt + 32'(r_dn_valid);
      r_stall_cnt <= r_stall_cnt + 32'(|w_busy && !w_gnt);
    end
  end
  assign flit_count  = r_flit_cnt;
  assign stall_count = r_stall_cnt;
`else
  assign flit_count  = 32'd0;
  assign stall_count = 32'd0;
`endif
endmodule

// File: tb/tb_noc_credit_link_buf.sv
// tb_noc_credit_link_buf: self-checking bench for noc_credit_link_buf.
module tb_noc_credit_link_buf;
  logic        clk = 1'b0, reset = 1'b1;
  logic        up_flit_valid = 1'b0, dn_credit_valid = 1'b0;
  logic [1:0]  up_flit_vc = '0, dn_credit_vc = '0;
  logic [63:0] up_flit_data = '0;
  logic        up_credit_valid, dn_flit_valid, error;
  logic [1:0]  up_credit_vc, dn_flit_vc;
  logic [63:0] dn_flit_data;
  logic [31:0] flit_count, stall_count;
  int errs = 0, checks = 0, n_out = 0, n_cred = 0, snap = 0;
  logic [63:0] sbq [4][$];
  logic [1:0]  obs [$];
  typedef struct {
    logic [1:0]  vc;
    logic [63:0] data;
    logic [1:0]  exp_vc;
    logic [63:0] exp_data;
  } vec_t;
  vec_t tbl [4];
  noc_credit_link_buf #(.FLIT_WIDTH(64), .NUM_VCS(4), .BUF_DEPTH(4), .DN_CREDITS(4)) dut (
    .clk(clk), .reset(reset),
    .up_flit_valid(up_flit_valid), .up_flit_vc(up_flit_vc), .up_flit_data(up_flit_data),
    .up_credit_valid(up_credit_valid), .up_credit_vc(up_credit_vc),
    .dn_flit_valid(dn_flit_valid), .dn_flit_vc(dn_flit_vc), .dn_flit_data(dn_flit_data),
    .dn_credit_valid(dn_credit_valid), .dn_credit_vc(dn_credit_vc),
    .error(error), .flit_count(flit_count), .stall_count(stall_count)
  );
  always #5 clk = ~clk;
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h, required %0h", nm, act, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
    n_cred += int'(up_credit_valid);
    if (dn_flit_valid) begin
      n_out++;
      obs.push_back(dn_flit_vc);
      if (sbq[dn_flit_vc].size() == 0) begin
        checks++;
        errs++;
        $display("FAIL unexpected_flit: got vc %0d data %0h, required no flit", dn_flit_vc, dn_flit_data);
      end else chk("dn_data", dn_flit_data, sbq[dn_flit_vc].pop_front());
    end
  endtask
  task automatic drive(input logic fv, input logic [1:0] fvc, input logic [63:0] d,
                       input logic cv, input logic [1:0] cvc);
    up_flit_valid = fv;
    up_flit_vc = fvc;
    up_flit_data = d;
    dn_credit_valid = cv;
    dn_credit_vc = cvc;
    tick();
  endtask
  task automatic send(input logic [1:0] vc, input logic [63:0] d, input bit keep);
    if (keep) sbq[vc].push_back(d);
    drive(1'b1, vc, d, 1'b0, 2'd0);
  endtask
  task automatic credit(input logic [1:0] vc);
    drive(1'b0, 2'd0, 64'd0, 1'b1, vc);
  endtask
  task automatic idle(input int n);
    repeat (n) drive(1'b0, 2'd0, 64'd0, 1'b0, 2'd0);
  endtask
  task automatic do_reset();
    reset = 1'b1;
    for (int v = 0; v < 4; v++) sbq[v].delete();
    idle(1);
    reset = 1'b0;
    n_out = 0;
    n_cred = 0;
    obs.delete();
  endtask
  task automatic check_zero(input string tag);
    chk({tag, "_dn_valid"}, 64'(dn_flit_valid), 64'd0);
    chk({tag, "_dn_vc"}, 64'(dn_flit_vc), 64'd0);
    chk({tag, "_dn_data"}, dn_flit_data, 64'd0);
    chk({tag, "_up_credit"}, 64'(up_credit_valid), 64'd0);
    chk({tag, "_up_credit_vc"}, 64'(up_credit_vc), 64'd0);
    chk({tag, "_error"}, 64'(error), 64'd0);
    chk({tag, "_flit_count"}, 64'(flit_count), 64'd0);
    chk({tag, "_stall_count"}, 64'(stall_count), 64'd0);
  endtask
  task automatic check_stats(input string tag, input int exp_flits);
`ifdef NOC_LINK_STATS_EN
    chk({tag, "_flit_count"}, 64'(flit_count), 64'(exp_flits));
`else
    chk({tag, "_flit_count"}, 64'(flit_count), 64'd0);
    chk({tag, "_stall_count"}, 64'(stall_count), 64'd0);
`endif
  endtask
  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
  initial begin
    tbl[0] = '{vc: 2'd2, data: 64'hA5, exp_vc: 2'd2, exp_data: 64'hA5};
    tbl[1] = '{vc: 2'd0, data: 64'hDEAD_BEEF_0123_4567, exp_vc: 2'd0, exp_data: 64'hDEAD_BEEF_0123_4567};
    tbl[2] = '{vc: 2'd3, data: 64'hFFFF_FFFF_FFFF_FFFF, exp_vc: 2'd3, exp_data: 64'hFFFF_FFFF_FFFF_FFFF};
    tbl[3] = '{vc: 2'd1, data: 64'h8000_0000_0000_0001, exp_vc: 2'd1, exp_data: 64'h8000_0000_0000_0001};
    do_reset();
    check_zero("reset");
    for (int t = 0; t < 4; t++) begin
      do_reset();
      send(tbl[t].vc, tbl[t].data, 1'b1);
      chk("lat_cycle1_valid", 64'(dn_flit_valid), 64'd0);
      idle(1);
      chk("lat_cycle2_valid", 64'(dn_flit_valid), 64'd1);
      chk("lat_vc", 64'(dn_flit_vc), 64'(tbl[t].exp_vc));
      chk("lat_data", dn_flit_data, tbl[t].exp_data);
      chk("lat_up_credit", 64'(up_credit_valid), 64'd1);
      chk("lat_up_credit_vc", 64'(up_credit_vc), 64'(tbl[t].exp_vc));
      idle(1);
      chk("lat_cycle3_valid", 64'(dn_flit_valid), 64'd0);
    end
    do_reset();
    for (int i = 0; i < 6; i++) send(2'd0, 64'h100 + 64'(i), 1'b1);
    idle(4);
    chk("exh_sent", 64'(n_out), 64'd4);
    credit(2'd0);
    chk("exh_pulse_early", 64'(dn_flit_valid), 64'd0);
    idle(1);
    chk("exh_pulse_valid", 64'(dn_flit_valid), 64'd1);
    chk("exh_pulse_vc", 64'(dn_flit_vc), 64'd0);
    sbq[1].push_back(64'h200);
    drive(1'b1, 2'd1, 64'h200, 1'b1, 2'd0);
    chk("rr_contend_early", 64'(dn_flit_valid), 64'd0);
    idle(1);
    chk("rr_contend_first", 64'(dn_flit_vc), 64'd1);
    idle(1);
    chk("rr_contend_second_valid", 64'(dn_flit_valid), 64'd1);
    chk("rr_contend_second", 64'(dn_flit_vc), 64'd0);
    idle(2);
    chk("exh_total", 64'(n_out), 64'd7);
    chk("exh_credits", 64'(n_cred), 64'd7);
    chk("exh_error", 64'(error), 64'd0);
    check_stats("exh", 7);
    do_reset();
    for (int i = 0; i < 8; i++) send(2'(i % 4), 64'h300 + 64'(i), 1'b1);
    idle(3);
    chk("rr_count", 64'(n_out), 64'd8);
    for (int k = 0; k < 8; k++) chk("rr_order", 64'(obs[k]), 64'(k % 4));
    do_reset();
    send(2'd2, 64'h400, 1'b1);
    credit(2'd2);
    idle(2);
    chk("net_credit_error", 64'(error), 64'd0);
    for (int i = 0; i < 5; i++) send(2'd2, 64'h410 + 64'(i), i < 4);
    idle(4);
    chk("net_credit_sent", 64'(n_out), 64'd5);
    chk("net_credit_error2", 64'(error), 64'd0);
    do_reset();
    credit(2'd3);
    chk("cred_ovf_error", 64'(error), 64'd1);
    for (int i = 0; i < 5; i++) send(2'd3, 64'h500 + 64'(i), i < 4);
    idle(4);
    chk("cred_ovf_sat", 64'(n_out), 64'd4);
    do_reset();
    for (int i = 0; i < 4; i++) send(2'd1, 64'h600 + 64'(i), 1'b1);
    idle(3);
    snap = n_cred;
    for (int i = 0; i < 5; i++) begin
      send(2'd1, 64'h610 + 64'(i), i < 4);
      if (i == 3) chk("ovf_before_drop", 64'(error), 64'd0);
    end
    chk("ovf_error", 64'(error), 64'd1);
    idle(3);
    chk("ovf_no_credit", 64'(n_cred - snap), 64'd0);
    for (int i = 0; i < 4; i++) credit(2'd1);
    idle(4);
    chk("ovf_credits_returned", 64'(n_cred - snap), 64'd4);
    chk("ovf_drained", 64'(sbq[1].size()), 64'd0);
    chk("ovf_sticky", 64'(error), 64'd1);
    do_reset();
    for (int i = 0; i < 8; i++) send(2'd1, 64'h700 + 64'(i), 1'b1);
    idle(3);
    credit(2'd1);
    send(2'd1, 64'h7FF, 1'b1);
    idle(1);
    chk("full_deq_write_error", 64'(error), 64'd0);
    for (int i = 0; i < 4; i++) credit(2'd1);
    idle(4);
    chk("full_deq_total", 64'(n_out), 64'd9);
    chk("full_deq_drained", 64'(sbq[1].size()), 64'd0);
    do_reset();
    for (int i = 0; i < 3; i++) send(2'd0, 64'h800 + 64'(i), 1'b1);
    do_reset();
    check_zero("mid_reset");
    idle(5);
    chk("mid_reset_no_flits", 64'(n_out), 64'd0);
    chk("mid_reset_no_credits", 64'(n_cred), 64'd0);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
